fir_multichannel_stream: RTL and testbench
==========================================

# fir_multichannel_stream

Time-multiplexed, multi-channel, linear-phase FIR filter with AXI-Stream input and output. Each input beat carries one sample of the channel named in its TID, and each channel keeps its own delay line. All channels share one symmetric coefficient set, which is writable at run time. The block sits between a sample-source stream and a downstream stream consumer, and it reports per-channel overflow plus activity status.

## Interface
- N_CHANNELS, 4, number of independent channels.
- N_TAPS, 32, filter length; must be even. N_TAPS/2 unique coefficients are stored.
- DATA_WIDTH, 16, signed sample width (Q1.15).
- COEFF_WIDTH, 16, signed coefficient width (Q1.15).
- TID_WIDTH, $clog2(N_CHANNELS), channel-ID width.
- aclk  in  1  sole clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  input handshake.
- s_axis_tdata  in  DATA_WIDTH  signed input sample.
- s_axis_tid  in  TID_WIDTH  channel of the sample; values ≥ N_CHANNELS are accepted and their data is discarded.
- s_axis_tlast  in  1  passed through to the output.
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  output handshake.
- m_axis_tdata  out  DATA_WIDTH  signed filtered sample.
- m_axis_tid, m_axis_tlast  out  TID_WIDTH, 1  TID and TLAST of the matching input beat.
- coeff_wr_en  in  1  coefficient write strobe.
- coeff_wr_addr  in  $clog2(N_TAPS/2)  coefficient index k.
- coeff_wr_data  in  COEFF_WIDTH  signed coefficient value.
- bypass_mode  in  1  when 1, output equals the input sample.
- overflow_flag  out  N_CHANNELS  sticky per-channel saturation flags.
- filter_busy  out  1  high when any pipeline stage holds a valid beat.
- sample_count  out  32  count of accepted input beats; wraps modulo 2^32.

## Operation
- **Reset** clears the following:
  - all delay lines, pipeline valid bits, outputs, overflow_flag and sample_count go to 0;
  - m_axis_tvalid = 0;
  - coefficients load the default set: c[15] = 16384 (0.5), all other c[k] = 0.
- **Coefficient mapping:** c[k] supplies both h[k] and h[N_TAPS-1-k].
  - A write with coeff_wr_en = 1 sets c[coeff_wr_addr] = coeff_wr_data at the clock edge.
  - The new value applies to beats accepted on later cycles.
- **Delay line update:** on each accepted beat, the delay line of channel tid shifts. x[0] becomes the new sample; the other channels are untouched.
- **Filter arithmetic:**
  - Pre-add: p[k] = x[k] + x[N_TAPS-1-k], 17-bit signed.
  - Multiply: p[k]·c[k].
  - Sum all products in a 38-bit signed accumulator.
  - Add 2^14 to the sum, then arithmetic-shift right by 15.
  - Saturate to the range [-32768, 32767].
  - If saturation occurs, overflow_flag[tid] is set to 1 and stays set until reset.
- **Bypass:** when bypass_mode = 1 at acceptance, m_axis_tdata equals s_axis_tdata.
  - The delay line still updates and latency is unchanged.
  - Overflow is never flagged in this mode.
- **Output:** exactly one output beat per accepted input beat, in the same order.

## Timing
- Pipeline depth is 9 stages:
  1. capture and shift;
  2. pre-add;
  3. multiply;
  4–7. 16→1 adder tree;
  8. round and saturate;
  9. output register.
- A beat accepted at edge n appears as m_axis_tvalid = 1 after edge n+9, provided no stall occurs.
- **Throughput:** one beat per cycle.
- **Stall rule:** stall = m_axis_tvalid & ~m_axis_tready.
  - s_axis_tready = ~stall, driven combinationally.
  - During a stall every stage holds its contents, and the m_axis_* outputs stay stable.
- The beat transfers on any edge where m_axis_tvalid & m_axis_tready.
- filter_busy is registered and reflects the valid bits of the current stages.
- sample_count increments on the same edge that accepts the beat.
- An asserted areset aborts in-flight beats immediately. Those beats are lost and are not output.

## Test plan
- **Impulse on channel 0, default coefficients:** input 1000 followed by 39 zeros, all with tid = 0.
  - Required response: outputs 15 and 16 are 500; every other output is 0.
  - The first output appears 9 cycles after its input.
- **Channel isolation:** interleave an impulse of 1000 on ch0 with a constant -2000 on ch1.
  - Required response: ch0 outputs match the impulse test.
  - ch1 settles at -2000 from its 17th beat onward; m_axis_tid matches each input.
- **Coefficient write and saturation:**
  - Write c[15] = 32767 and c[14] = 32767, then send a constant 32767 on ch2.
  - Required response: output clamps at 32767 and overflow_flag = 4'b0100.
  - Only reset clears the flag.
- **Backpressure:** hold m_axis_tready low for 5 cycles in the middle of a stream.
  - Required response: s_axis_tready is low during the stall and m_axis_tdata is stable.
  - No beats are lost or duplicated; sample_count equals the number of inputs.
- **Bypass:** with bypass_mode = 1, send 123, -456, 32767.
  - Required response: outputs are the same values, each 9 cycles later, with no overflow.
- **Reset mid-stream:** assert areset while 5 beats are in flight.
  - Required response: m_axis_tvalid, filter_busy and sample_count go to 0 immediately.
  - After reset, an impulse reproduces the first test.

Source files
------------

// File: rtl/fir_multichannel_stream.sv
`default_nettype none
// ============================================================================
// Module   : fir_multichannel_stream
// Purpose  : Time-multiplexed multi-channel symmetric FIR, AXI-Stream in/out.
// Revision : 1.0 - initial release
// ============================================================================
module fir_multichannel_stream #(
  parameter int N_CHANNELS  = 4,
  parameter int N_TAPS      = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int TID_WIDTH   = $clog2(N_CHANNELS)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic signed [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [TID_WIDTH-1:0]          s_axis_tid,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic signed [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [TID_WIDTH-1:0]          m_axis_tid,
  output logic                          m_axis_tlast,
  input  logic                          coeff_wr_en,
  input  logic [$clog2(N_TAPS/2)-1:0]   coeff_wr_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_wr_data,
  input  logic                          bypass_mode,
  output logic [N_CHANNELS-1:0]         overflow_flag,
  output logic                          filter_busy,
  output logic [31:0]                   sample_count
);
  localparam int c_HALF = N_TAPS / 2;
  localparam int c_PW   = DATA_WIDTH + 1;
  localparam int c_MW   = c_PW + COEFF_WIDTH;
  localparam int c_AW   = c_MW + $clog2(c_HALF) + 1;
  localparam int c_TREE = 16;  // fixed four-level tree, holds up to 16 products
  localparam int c_NST  = 10;  // capture, shift .. output
  localparam int c_NBY  = 8;   // bypass/raw sample only needed up to saturation
  localparam int c_FRAC = COEFF_WIDTH - 1;
  localparam logic signed [c_AW-1:0] c_RND     = c_AW'(longint'(1) <<< (c_FRAC - 1));
  localparam logic signed [c_AW-1:0] c_SAT_MAX = c_AW'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [c_AW-1:0] c_SAT_MIN = c_AW'(-(longint'(1) <<< (DATA_WIDTH - 1)));
  localparam logic signed [COEFF_WIDTH-1:0] c_COEF_DEF = COEFF_WIDTH'(longint'(1) <<< (COEFF_WIDTH - 2));

  logic                         w_adv;
  logic                         w_busy_nxt;
  logic                         w_tid_ok;
  logic                         w_ovf_tid_ok;
  logic [c_NST-1:0]             r_vld;
  logic [c_NST-1:0]             r_last;
  logic [c_NBY-1:0]             r_byp;
  logic [TID_WIDTH-1:0]         r_tid [c_NST];
  logic signed [DATA_WIDTH-1:0] r_raw [c_NBY];
  logic signed [COEFF_WIDTH-1:0] r_coef     [c_HALF];
  logic signed [COEFF_WIDTH-1:0] r_cap_coef [c_HALF];
  logic signed [COEFF_WIDTH-1:0] r_s1_coef  [c_HALF];
  logic signed [COEFF_WIDTH-1:0] r_s2_c     [c_HALF];
  logic signed [DATA_WIDTH-1:0] r_dline [N_CHANNELS][N_TAPS-1];
  logic signed [DATA_WIDTH-1:0] r_s1_win [N_TAPS];
  logic signed [c_PW-1:0]       r_s2_p [c_HALF];
  logic signed [c_MW-1:0]       r_s3_m [c_HALF];
  logic signed [c_AW-1:0]       w_lvl0 [c_TREE];
  logic signed [c_AW-1:0]       r_s4 [8];
  logic signed [c_AW-1:0]       r_s5 [4];
  logic signed [c_AW-1:0]       r_s6 [2];
  logic signed [c_AW-1:0]       r_s7;
  logic signed [c_AW-1:0]       w_rnd;
  logic                         w_hi;
  logic                         w_lo;
  logic signed [DATA_WIDTH-1:0] w_sat_y;
  logic signed [DATA_WIDTH-1:0] r_s8_y;
  logic signed [DATA_WIDTH-1:0] r_out;
  logic [N_CHANNELS-1:0]        r_ovf;
  logic                         r_busy;
  logic [31:0]                  r_cnt;

  // Every stage advances together unless the output register is blocked.
  assign w_adv         = ~(r_vld[c_NST-1] & ~m_axis_tready);
  assign s_axis_tready = w_adv;
  assign w_tid_ok      = int'(r_tid[0]) < N_CHANNELS;
  assign w_ovf_tid_ok  = int'(r_tid[7]) < N_CHANNELS;
  assign w_busy_nxt    = w_adv ? (s_axis_tvalid | (|r_vld[c_NST-2:0])) : (|r_vld);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_vld  <= '0;
      r_last <= '0;
      r_byp  <= '0;
      for (int i = 0; i < c_NST; i++) r_tid[i] <= '0;
      for (int i = 0; i < c_NBY; i++) r_raw[i] <= '0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_adv) begin
        r_vld    <= {r_vld[c_NST-2:0], s_axis_tvalid};
        r_last   <= {r_last[c_NST-2:0], s_axis_tlast};
        r_byp    <= {r_byp[c_NBY-2:0], bypass_mode};
        r_tid[0] <= s_axis_tid;
        r_raw[0] <= s_axis_tdata;
        for (int i = 1; i < c_NST; i++) r_tid[i] <= r_tid[i-1];
        for (int i = 1; i < c_NBY; i++) r_raw[i] <= r_raw[i-1];
        if (s_axis_tvalid) r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  // Coefficient set is snapshotted at capture so later writes never touch beats in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < c_HALF; k++) begin
        r_coef[k]     <= (k == c_HALF - 1) ? c_COEF_DEF : '0;
        r_cap_coef[k] <= '0;
        r_s1_coef[k]  <= '0;
        r_s2_c[k]     <= '0;
      end
    end else begin
      if (coeff_wr_en) r_coef[coeff_wr_addr] <= coeff_wr_data;
      if (w_adv) begin
        r_cap_coef <= r_coef;
        r_s1_coef  <= r_cap_coef;
        r_s2_c     <= r_s1_coef;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int c = 0; c < N_CHANNELS; c++)
        for (int k = 0; k < N_TAPS - 1; k++) r_dline[c][k] <= '0;
      for (int k = 0; k < N_TAPS; k++) r_s1_win[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < N_TAPS; k++) r_s1_win[k] <= '0;
      if (r_vld[0] && w_tid_ok) begin
        r_s1_win[0]          <= r_raw[0];
        r_dline[r_tid[0]][0] <= r_raw[0];
        for (int k = 1; k < N_TAPS; k++) r_s1_win[k] <= r_dline[r_tid[0]][k-1];
        for (int k = 1; k < N_TAPS - 1; k++) r_dline[r_tid[0]][k] <= r_dline[r_tid[0]][k-1];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < c_HALF; k++) begin
        r_s2_p[k] <= '0;
        r_s3_m[k] <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < c_HALF; k++) begin
        r_s2_p[k] <= c_PW'(r_s1_win[k]) + c_PW'(r_s1_win[N_TAPS-1-k]);
        r_s3_m[k] <= c_MW'(r_s2_p[k]) * c_MW'(r_s2_c[k]);
      end
    end
  end

  for (genvar gi = 0; gi < c_TREE; gi++) begin : g_pad
    if (gi < c_HALF) begin : g_prod
      assign w_lvl0[gi] = c_AW'(r_s3_m[gi]);
    end else begin : g_zero
      assign w_lvl0[gi] = '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 8; i++) r_s4[i] <= '0;
      for (int i = 0; i < 4; i++) r_s5[i] <= '0;
      for (int i = 0; i < 2; i++) r_s6[i] <= '0;
      r_s7 <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < 8; i++) r_s4[i] <= w_lvl0[2*i] + w_lvl0[2*i+1];
      for (int i = 0; i < 4; i++) r_s5[i] <= r_s4[2*i] + r_s4[2*i+1];
      for (int i = 0; i < 2; i++) r_s6[i] <= r_s5[2*i] + r_s5[2*i+1];
      r_s7 <= r_s6[0] + r_s6[1];
    end
  end

  always_comb begin
    w_rnd = (r_s7 + c_RND) >>> c_FRAC;
    w_hi  = w_rnd > c_SAT_MAX;
    w_lo  = w_rnd < c_SAT_MIN;
    if (w_hi)      w_sat_y = c_SAT_MAX[DATA_WIDTH-1:0];
    else if (w_lo) w_sat_y = c_SAT_MIN[DATA_WIDTH-1:0];
    else           w_sat_y = w_rnd[DATA_WIDTH-1:0];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s8_y <= '0;
      r_out  <= '0;
      r_ovf  <= '0;
    end else if (w_adv) begin
      r_s8_y <= r_byp[7] ? r_raw[7] : w_sat_y;
      r_out  <= r_s8_y;
      if (r_vld[7] && !r_byp[7] && (w_hi || w_lo) && w_ovf_tid_ok) r_ovf[r_tid[7]] <= 1'b1;
    end
  end

  assign m_axis_tvalid = r_vld[c_NST-1];
  assign m_axis_tdata  = r_out;
  assign m_axis_tid    = r_tid[c_NST-1];
  assign m_axis_tlast  = r_last[c_NST-1];
  assign overflow_flag = r_ovf;
  assign filter_busy   = r_busy;
  assign sample_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fir_multichannel_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_multichannel_stream
// Purpose  : Directed + randomized bench against a direct-form FIR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_multichannel_stream;
  localparam int N_CH   = 4;
  localparam int N_TAPS = 32;
  localparam int H      = N_TAPS / 2;

  logic               aclk = 1'b0;
  logic               areset;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic signed [15:0] s_axis_tdata;
  logic [1:0]         s_axis_tid;
  logic               s_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic signed [15:0] m_axis_tdata;
  logic [1:0]         m_axis_tid;
  logic               m_axis_tlast;
  logic               coeff_wr_en;
  logic [3:0]         coeff_wr_addr;
  logic signed [15:0] coeff_wr_data;
  logic               bypass_mode;
  logic [3:0]         overflow_flag;
  logic               filter_busy;
  logic [31:0]        sample_count;

  fir_multichannel_stream dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
    .bypass_mode(bypass_mode), .overflow_flag(overflow_flag),
    .filter_busy(filter_busy), .sample_count(sample_count)
  );

  always #5 aclk = ~aclk;

  typedef struct { int data; int tid; bit last; longint acc_cyc; } exp_t;
  typedef struct { int tid; int data; } obs_t;

  exp_t     q[$];
  obs_t     olog[$];
  int       hist [N_CH][N_TAPS];
  int       coef_m [H];
  logic [3:0] ovf_m;
  int       acc_cnt;
  int       n_err = 0;
  int       n_checks = 0;
  bit       chk_lat = 1'b1;
  longint   cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < N_TAPS; k++) hist[c][k] = 0;
    for (int k = 0; k < H; k++) coef_m[k] = 0;
    coef_m[H-1] = 16384;
    ovf_m   = '0;
    acc_cnt = 0;
    q.delete();
  endfunction

  // Direct-form convolution with h[k] = h[N-1-k] = c[k], rounded and clamped.
  function automatic void model_accept(int ch, int d, bit byp, bit last, longint when);
    longint acc;
    int     y;
    for (int k = N_TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = d;
    acc = 0;
    for (int k = 0; k < N_TAPS; k++)
      acc += longint'(hist[ch][k]) * longint'(coef_m[(k < H) ? k : N_TAPS - 1 - k]);
    acc = (acc + 16384) >>> 15;
    if (byp) y = d;
    else if (acc > 32767) begin y = 32767; ovf_m[ch] = 1'b1; end
    else if (acc < -32768) begin y = -32768; ovf_m[ch] = 1'b1; end
    else y = int'(acc);
    acc_cnt++;
    q.push_back('{data: y, tid: ch, last: last, acc_cyc: when});
  endfunction

  function automatic int nth(int tid, int n);
    int seen = 0;
    foreach (olog[i]) begin
      if (olog[i].tid == tid) begin
        if (seen == n) return olog[i].data;
        seen++;
      end
    end
    return -999999;
  endfunction

  always @(negedge aclk) begin
    exp_t e;
    if (!areset && m_axis_tvalid) begin
      if (q.size() == 0) check("unexpected_beat", q.size(), 1);
      else if (!m_axis_tready) check("stall_hold", m_axis_tdata, q[0].data);
      else begin
        e = q.pop_front();
        check("out_data", m_axis_tdata, e.data);
        check("out_tid", m_axis_tid, e.tid);
        check("out_last", m_axis_tlast, e.last);
        if (chk_lat) check("latency", cyc - e.acc_cyc, 9);
        olog.push_back('{tid: int'(m_axis_tid), data: int'(m_axis_tdata)});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int ch, input int d, input bit last);
    int w = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tid    = 2'(ch);
    s_axis_tdata  = 16'(d);
    s_axis_tlast  = last;
    @(negedge aclk);
    while (!s_axis_tready && w < 100) begin @(negedge aclk); w++; end
    if (!s_axis_tready) check("accept_timeout", s_axis_tready, 1);
    else model_accept(ch, d, bypass_mode, last, cyc + 1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic write_coef(input int k, input int v);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = 4'(k);
    coeff_wr_data = 16'(v);
    @(posedge aclk); #1;
    coeff_wr_en = 1'b0;
    coef_m[k]   = v;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 500) begin @(posedge aclk); w++; end
    check("drain_empty", q.size(), 0);
    repeat (3) @(posedge aclk);
    #1;
    check("busy_idle", filter_busy, 0);
    check("sample_count", sample_count, acc_cnt);
  endtask

  task automatic impulse_test();
    olog.delete();
    send(0, 1000, 1'b0);
    check("busy_active", filter_busy, 1);
    for (int i = 0; i < 39; i++) send(0, 0, i == 38);
    drain();
    check("imp_count", olog.size(), 40);
    check("imp_out0", nth(0, 0), 0);
    check("imp_out15", nth(0, 15), 500);
    check("imp_out16", nth(0, 16), 500);
    check("imp_out17", nth(0, 17), 0);
    check("imp_out39", nth(0, 39), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tid = '0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b1; coeff_wr_en = 1'b0;
    coeff_wr_addr = '0; coeff_wr_data = '0; bypass_mode = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", filter_busy, 0);
    check("rst_count", sample_count, 0);
    check("rst_ovf", overflow_flag, 0);
    check("rst_tready", s_axis_tready, 1);
    areset = 1'b0;
    @(posedge aclk); #1;

    impulse_test();

    // Channel isolation: impulse on ch0 interleaved with a constant on ch1.
    olog.delete();
    for (int i = 0; i < 20; i++) begin
      send(0, (i == 0) ? 1000 : 0, 1'b0);
      send(1, -2000, i == 19);
    end
    drain();
    check("iso_ch0_15", nth(0, 15), 500);
    check("iso_ch0_16", nth(0, 16), 500);
    check("iso_ch1_15", nth(1, 15), -1000);
    check("iso_ch1_16", nth(1, 16), -2000);
    check("iso_ch1_19", nth(1, 19), -2000);

    // Backpressure: random stream with a 5-cycle output stall in the middle.
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768,
               1'($urandom_range(0, 1)));
      end
      begin
        repeat (12) @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        repeat (5) begin
          @(negedge aclk);
          check("stall_tready", s_axis_tready, 0);
          check("stall_tvalid", m_axis_tvalid, 1);
        end
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    // Saturation on ch2 with both centre coefficients at full scale.
    write_coef(15, 32767);
    write_coef(14, 32767);
    olog.delete();
    for (int i = 0; i < 20; i++) send(2, 32767, i == 19);
    drain();
    check("sat_last", nth(2, 19), 32767);
    check("sat_ovf", overflow_flag, 4'b0100);
    check("sat_ovf_model", overflow_flag, ovf_m);

    // Bypass: output mirrors input, no new overflow.
    bypass_mode = 1'b1;
    olog.delete();
    send(3, 123, 1'b0);
    send(3, -456, 1'b0);
    send(3, 32767, 1'b1);
    drain();
    bypass_mode = 1'b0;
    check("byp_0", nth(3, 0), 123);
    check("byp_1", nth(3, 1), -456);
    check("byp_2", nth(3, 2), 32767);
    check("byp_ovf", overflow_flag, 4'b0100);

    // Random coefficient set with random traffic on all channels.
    for (int k = 0; k < H; k++) write_coef(k, int'($urandom_range(0, 6000)) - 3000);
    for (int i = 0; i < 40; i++)
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768, 1'b0);
    drain();
    check("rnd_ovf_model", overflow_flag, ovf_m);

    // Reset with beats in flight.
    for (int i = 0; i < 5; i++) send(0, int'($urandom_range(0, 2000)), 1'b0);
    check("pre_rst_count", sample_count, acc_cnt);
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_busy", filter_busy, 0);
    check("mid_rst_count", sample_count, 0);
    check("mid_rst_ovf", overflow_flag, 0);
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    impulse_test();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
